// File: rtl/sevenseg_scan_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_capture_if
// Description : Display-side bus between a 2-digit multiplexed 7-segment
//               scanner (master) and the readback/capture block (slave).
//               Carries the active-low anode/segment lines plus the decoded
//               readback results.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_scan_capture_if;
  logic [3:0] an;            // anode enables, active-low
  logic [6:0] seg;           // segments, active-low, {g,f,e,d,c,b,a}
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] digit_valid;
  logic [1:0] pattern_err;
  logic       scan_active;
  logic       frame_strobe;

  // Scanner side: drives the display lines, observes the readback.
  modport master (
    output an, seg,
    input  digit0, digit1, digit_valid, pattern_err, scan_active, frame_strobe
  );

  // Capture side: samples the display lines, reports decoded digits.
  modport slave (
    input  an, seg,
    output digit0, digit1, digit_valid, pattern_err, scan_active, frame_strobe
  );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_capture
// Description : Samples a 2-digit multiplexed, active-low 7-segment display,
//               qualifies each digit window for SETTLE_CYCLES of stability
//               and decodes the segment pattern back to a hex nibble.
//               Flags undecodable patterns, pulses once per digit0->digit1
//               frame, and declares the scan dead after TIMEOUT_CYCLES with
//               no qualified capture.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_capture #(
  parameter int SETTLE_CYCLES  = 16,     // must be >= 2
  parameter int TIMEOUT_CYCLES = 16384   // must exceed one scan frame
) (
  input  wire logic            Clk,
  input  wire logic            reset,
  sevenseg_scan_capture_if.slave bus
);

  localparam int c_STABLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int c_TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_STABLE_W-1:0]  c_SETTLE   = c_STABLE_W'(SETTLE_CYCLES);
  localparam logic [c_STABLE_W-1:0]  c_SETTLE_M = c_STABLE_W'(SETTLE_CYCLES - 1);
  localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT  = c_TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT_M = c_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] c_AN_D0 = 4'b1110;
  localparam logic [3:0] c_AN_D1 = 4'b1101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Synchronizer chain and previous-cycle copies.
  logic [3:0] r_an_meta, r_an_sync, r_an_prev;
  logic [6:0] r_seg_meta, r_seg_sync, r_seg_prev;

  // Control state.
  state_t                 r_state;
  logic [c_STABLE_W-1:0]  r_stable;
  logic [c_TIMEOUT_W-1:0] r_timeout;
  logic                   r_d0_seen;

  // Registered outputs.
  logic [3:0] r_digit0, r_digit1;
  logic [1:0] r_digit_valid, r_pattern_err;
  logic       r_scan_active, r_frame_strobe;

  // Combinational qualifiers.
  logic       w_legal;
  logic       w_changed;
  logic       w_capture;
  logic       w_sel_d1;
  logic       w_match;
  logic [3:0] w_value;

  assign w_legal   = (r_an_sync == c_AN_D0) || (r_an_sync == c_AN_D1);
  assign w_changed = {r_an_sync, r_seg_sync} != {r_an_prev, r_seg_prev};
  assign w_sel_d1  = (r_an_sync == c_AN_D1);
  // A stable cycle in QUALIFY always carries a legal code: entry requires
  // one, and any change to a non-legal code leaves QUALIFY.
  assign w_capture = (r_state == QUALIFY) && !w_changed && (r_stable == c_SETTLE_M);

  // Two-flop synchronizers plus one more stage for change detection.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_an_meta  <= 4'b1111;
      r_an_sync  <= 4'b1111;
      r_an_prev  <= 4'b1111;
      r_seg_meta <= 7'h7F;
      r_seg_sync <= 7'h7F;
      r_seg_prev <= 7'h7F;
    end else begin
      r_an_meta  <= bus.an;
      r_an_sync  <= r_an_meta;
      r_an_prev  <= r_an_sync;
      r_seg_meta <= bus.seg;
      r_seg_sync <= r_seg_meta;
      r_seg_prev <= r_seg_sync;
    end
  end

  // Active-low {g..a} pattern to hex nibble; w_match low for anything else.
  always_comb begin
    w_match = 1'b1;
    w_value = 4'h0;
    case (r_seg_sync)
      7'h40:   w_value = 4'h0;
      7'h79:   w_value = 4'h1;
      7'h24:   w_value = 4'h2;
      7'h30:   w_value = 4'h3;
      7'h19:   w_value = 4'h4;
      7'h12:   w_value = 4'h5;
      7'h02:   w_value = 4'h6;
      7'h78:   w_value = 4'h7;
      7'h00:   w_value = 4'h8;
      7'h10:   w_value = 4'h9;
      7'h08:   w_value = 4'hA;
      7'h03:   w_value = 4'hB;
      7'h46:   w_value = 4'hC;
      7'h21:   w_value = 4'hD;
      7'h06:   w_value = 4'hE;
      7'h0E:   w_value = 4'hF;
      default: w_match = 1'b0;
    endcase
  end

  // Window qualification FSM, capture/decode results, frame and timeout.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_stable       <= '0;
      r_timeout      <= '0;
      r_d0_seen      <= 1'b0;
      r_digit0       <= 4'h0;
      r_digit1       <= 4'h0;
      r_digit_valid  <= 2'b00;
      r_pattern_err  <= 2'b00;
      r_scan_active  <= 1'b0;
      r_frame_strobe <= 1'b0;
    end else begin
      r_frame_strobe <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_state  <= QUALIFY;
            r_stable <= c_STABLE_W'(1);
          end
        end
        QUALIFY: begin
          if (w_changed) begin
            if (w_legal) r_stable <= c_STABLE_W'(1);
            else         r_state  <= IDLE;
          end else if (r_stable == c_SETTLE_M) begin
            r_stable <= c_SETTLE;
            r_state  <= HOLD;
          end else begin
            r_stable <= r_stable + 1'b1;
          end
        end
        HOLD: begin
          // A glitch-then-settle inside one window recaptures.
          if (w_changed) begin
            if (w_legal) begin
              r_state  <= QUALIFY;
              r_stable <= c_STABLE_W'(1);
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_capture) begin
        r_timeout     <= '0;
        r_scan_active <= 1'b1;
        if (w_sel_d1) begin
          if (w_match) begin
            r_digit1         <= w_value;
            r_digit_valid[1] <= 1'b1;
            r_pattern_err[1] <= 1'b0;
          end else begin
            r_pattern_err[1] <= 1'b1;
          end
          if (r_d0_seen) begin
            r_frame_strobe <= 1'b1;
            r_d0_seen      <= 1'b0;
          end
        end else begin
          if (w_match) begin
            r_digit0         <= w_value;
            r_digit_valid[0] <= 1'b1;
            r_pattern_err[0] <= 1'b0;
          end else begin
            r_pattern_err[0] <= 1'b1;
          end
          r_d0_seen <= 1'b1;
        end
      end else if (r_timeout != c_TIMEOUT) begin
        r_timeout <= r_timeout + 1'b1;
        // Act only on the transition into saturation.
        if (r_timeout == c_TIMEOUT_M) begin
          r_scan_active <= 1'b0;
          r_digit_valid <= 2'b00;
          r_d0_seen     <= 1'b0;
        end
      end
    end
  end

  assign bus.digit0       = r_digit0;
  assign bus.digit1       = r_digit1;
  assign bus.digit_valid  = r_digit_valid;
  assign bus.pattern_err  = r_pattern_err;
  assign bus.scan_active  = r_scan_active;
  assign bus.frame_strobe = r_frame_strobe;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan_capture
// Description : Directed, table-driven bench for sevenseg_scan_capture with
//               hand-written sequences for latency, settle, strobe and
//               timeout corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_capture;

  logic Clk   = 1'b0;
  logic reset = 1'b1;

  sevenseg_scan_capture_if bus ();

  sevenseg_scan_capture #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (16384)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_strobe = 0;

  // Count strobe-high cycles away from the active edge.
  always @(negedge Clk) if (bus.frame_strobe) n_strobe++;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         cycles;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] valid;
    logic [1:0] err;
    logic       active;
    int         strb;
  } vec_t;

  vec_t vecs [10];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [1:0] valid, input logic [1:0] err, input logic active);
    check({tag, ".digit0"},      int'(bus.digit0),      int'(d0));
    check({tag, ".digit1"},      int'(bus.digit1),      int'(d1));
    check({tag, ".digit_valid"}, int'(bus.digit_valid), int'(valid));
    check({tag, ".pattern_err"}, int'(bus.pattern_err), int'(err));
    check({tag, ".scan_active"}, int'(bus.scan_active), int'(active));
  endtask

  initial begin
    int s0;

    vecs[0] = '{4'b1111, 7'h7F, 4096, 4'h3, 4'h5, 2'b11, 2'b00, 1'b1, 0};
    vecs[1] = '{4'b1110, 7'h30, 4096, 4'h3, 4'h5, 2'b11, 2'b00, 1'b1, 0};
    vecs[2] = '{4'b1101, 7'h12, 4096, 4'h3, 4'h5, 2'b11, 2'b00, 1'b1, 1};
    vecs[3] = '{4'b1111, 7'h7F, 4096, 4'h3, 4'h5, 2'b11, 2'b00, 1'b1, 0};
    vecs[4] = '{4'b1101, 7'h7F, 4096, 4'h3, 4'h5, 2'b11, 2'b10, 1'b1, 0};
    vecs[5] = '{4'b1101, 7'h06, 4096, 4'h3, 4'hE, 2'b11, 2'b00, 1'b1, 0};
    vecs[6] = '{4'b1110, 7'h21, 4096, 4'hD, 4'hE, 2'b11, 2'b00, 1'b1, 0};
    vecs[7] = '{4'b1100, 7'h00, 8000, 4'hD, 4'hE, 2'b11, 2'b00, 1'b1, 0};
    vecs[8] = '{4'b0110, 7'h00, 3000, 4'hD, 4'hE, 2'b11, 2'b00, 1'b1, 0};
    vecs[9] = '{4'b1101, 7'h12, 4096, 4'hD, 4'h5, 2'b11, 2'b00, 1'b1, 1};

    bus.an  = 4'b1111;
    bus.seg = 7'h7F;
    reset   = 1'b1;
    tick(3);
    check_outs("reset", 4'h0, 4'h0, 2'b00, 2'b00, 1'b0);
    check("reset.frame_strobe", int'(bus.frame_strobe), 0);

    // Reset in the middle of a qualify window.
    reset   = 1'b0;
    bus.an  = 4'b1110;
    bus.seg = 7'h30;
    tick(10);
    reset = 1'b1;
    tick(3);
    check_outs("midrst", 4'h0, 4'h0, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    tick(17);
    check("rst_lat17.digit_valid", int'(bus.digit_valid), 0);
    tick(1);
    check_outs("rst_lat18", 4'h3, 4'h0, 2'b01, 2'b00, 1'b1);

    // Digit1 window: exact latency and a single-cycle frame strobe.
    s0      = n_strobe;
    bus.an  = 4'b1101;
    bus.seg = 7'h12;
    tick(17);
    check_outs("d1_lat17", 4'h3, 4'h0, 2'b01, 2'b00, 1'b1);
    check("d1_lat17.frame_strobe", int'(bus.frame_strobe), 0);
    tick(1);
    check_outs("d1_lat18", 4'h3, 4'h5, 2'b11, 2'b00, 1'b1);
    check("d1_lat18.frame_strobe", int'(bus.frame_strobe), 1);
    tick(1);
    check("d1_lat19.frame_strobe", int'(bus.frame_strobe), 0);
    check("d1.strobe_count", n_strobe - s0, 1);

    // Table: nominal frames, bad pattern, illegal anodes.
    for (int i = 0; i < 10; i++) begin
      s0      = n_strobe;
      bus.an  = vecs[i].an;
      bus.seg = vecs[i].seg;
      tick(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1,
                 vecs[i].valid, vecs[i].err, vecs[i].active);
      check($sformatf("vec%0d.strobes", i), n_strobe - s0, vecs[i].strb);
    end

    // Segments toggling faster than the settle window never capture.
    bus.an = 4'b1110;
    for (int i = 0; i < 19; i++) begin
      bus.seg = (i % 2 == 0) ? 7'h40 : 7'h79;
      tick(10);
      check($sformatf("settle_toggle%0d.digit0", i), int'(bus.digit0), 4'hD);
    end
    bus.seg = 7'h79;
    tick(17);
    check("settle17.digit0", int'(bus.digit0), 4'hD);
    tick(1);
    check_outs("settle18", 4'h1, 4'h5, 2'b11, 2'b00, 1'b1);

    // Scan stops: timeout exactly TIMEOUT_CYCLES after the last capture.
    bus.an  = 4'b1111;
    bus.seg = 7'h7F;
    tick(16383);
    check_outs("tmo16383", 4'h1, 4'h5, 2'b11, 2'b00, 1'b1);
    tick(1);
    check_outs("tmo16384", 4'h1, 4'h5, 2'b00, 2'b00, 1'b0);

    // Scan resumes: active again at the first capture.
    bus.an  = 4'b1110;
    bus.seg = 7'h30;
    tick(17);
    check("resume17.scan_active", int'(bus.scan_active), 0);
    tick(1);
    check_outs("resume18", 4'h3, 4'h5, 2'b01, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
